// File: rtl/cpu_halt_sequencer_pkg.sv
// Shared types for the halt/drain/dump sequencer.
// The state encoding is fixed so that other pipeline blocks and debug tooling can decode it.
package cpu_halt_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DUMP  = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_e;

    localparam logic [31:0] HALT_INST_WORD = 32'hFFFF_FFFF;

    // Bits needed to hold a count of 0..n-1.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/cpu_halt_sequencer_down_counter.sv
// Loadable down counter with a zero flag; used to time the post-halt pipeline drain.
// Load wins over decrement; decrement stops at zero.
module seq_down_counter #(
    parameter int W = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/cpu_halt_sequencer.sv
// Ends a CPU run: detects the halt word in ID, freezes fetch, drains EX/MEM/WB,
// then streams MainMemory words 0..DUMP_WORDS-1 over a valid/ready port.
module cpu_halt_sequencer
    import cpu_halt_sequencer_pkg::*;
#(
    parameter int          ADDR_W       = 9,
    parameter int          DUMP_WORDS   = 512,
    parameter int          DRAIN_CYCLES = 3,
    parameter logic [31:0] HALT_INST    = HALT_INST_WORD
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic [31:0]       Inst_D,
    output logic              Freeze_F,
    output logic              Bubble_D,
    output logic              DumpEN,
    output logic [ADDR_W-1:0] DumpAddr,
    input  logic [31:0]       MemReadData,
    output logic [31:0]       DumpData,
    output logic              DumpValid,
    input  logic              DumpReady,
    output logic              DumpLast,
    output logic              Halted,
    output logic              Done,
    output logic [31:0]       CycleCount
);

    localparam int unsigned      CNT_W     = cnt_width(DRAIN_CYCLES);
    localparam logic [CNT_W-1:0] DRAIN_LD  = CNT_W'(DRAIN_CYCLES - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DUMP_WORDS - 1);

    seq_state_e        state_q;
    logic              halted_q;
    logic              dump_vld_q;
    logic              done_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       cyc_q;
    logic              drain_zero;
    logic              halt_hit;
    logic              last_beat;

    assign halt_hit  = (state_q == ST_RUN) && (Inst_D == HALT_INST);
    assign last_beat = dump_vld_q && (addr_q == LAST_ADDR);

    seq_down_counter #(.W(CNT_W)) u_drain_cnt (
        .clk_i      (CLOCK),
        .rst_i      (RESET),
        .load_i     (halt_hit),
        .load_val_i (DRAIN_LD),
        .dec_i      (state_q == ST_DRAIN),
        .zero_o     (drain_zero)
    );

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q    <= ST_RUN;
            halted_q   <= 1'b0;
            dump_vld_q <= 1'b0;
            done_q     <= 1'b0;
            addr_q     <= '0;
            cyc_q      <= '0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    cyc_q <= cyc_q + 32'd1;
                    if (halt_hit) begin
                        state_q  <= ST_DRAIN;
                        halted_q <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (drain_zero) begin
                        state_q    <= ST_DUMP;
                        dump_vld_q <= 1'b1;
                    end
                end
                ST_DUMP: begin
                    if (DumpReady) begin
                        addr_q <= addr_q + 1'b1;
                        if (last_beat) begin
                            state_q    <= ST_DONE;
                            dump_vld_q <= 1'b0;
                            done_q     <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Freeze acts in the detection cycle so the halt word never enters EX.
    assign Freeze_F   = halt_hit | halted_q;
    assign Bubble_D   = halt_hit | halted_q;
    assign DumpEN     = dump_vld_q;
    assign DumpValid  = dump_vld_q;
    assign DumpAddr   = addr_q;
    assign DumpData   = dump_vld_q ? MemReadData : 32'd0;
    assign DumpLast   = last_beat;
    assign Halted     = halted_q;
    assign Done       = done_q;
    assign CycleCount = cyc_q;

endmodule

// File: tb/tb_cpu_halt_sequencer.sv
// Randomized bench for cpu_halt_sequencer against an event-count reference model.
module tb_cpu_halt_sequencer;

    localparam int          ADDR_W     = 4;
    localparam int          DUMP_WORDS = 12;
    localparam int          DRAIN      = 3;
    localparam logic [31:0] HALT       = 32'hFFFF_FFFF;

    logic              clk = 1'b0;
    logic              rst;
    logic [31:0]       inst_d;
    logic              freeze_f, bubble_d, dump_en, dump_valid, dump_ready, dump_last;
    logic              halted, done;
    logic [ADDR_W-1:0] dump_addr;
    logic [31:0]       mem_rdata, dump_data, cycle_count;
    logic [31:0]       mem [16];

    always #5 clk = ~clk;

    assign mem_rdata = mem[dump_addr];

    cpu_halt_sequencer #(
        .ADDR_W(ADDR_W), .DUMP_WORDS(DUMP_WORDS), .DRAIN_CYCLES(DRAIN), .HALT_INST(HALT)
    ) dut (
        .CLOCK(clk), .RESET(rst), .Inst_D(inst_d),
        .Freeze_F(freeze_f), .Bubble_D(bubble_d), .DumpEN(dump_en), .DumpAddr(dump_addr),
        .MemReadData(mem_rdata), .DumpData(dump_data), .DumpValid(dump_valid),
        .DumpReady(dump_ready), .DumpLast(dump_last), .Halted(halted), .Done(done),
        .CycleCount(cycle_count)
    );

    int errors = 0;
    int checks = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Reference model: counts of run cycles, cycles since halt, and accepted beats.
    int unsigned m_run;
    bit          m_halted;
    int          m_since;
    int          m_beats;

    task automatic model_reset();
        m_run = 0; m_halted = 0; m_since = 0; m_beats = 0;
    endtask

    initial begin
        logic [31:0] v;
        bit          e_dump, e_done, e_last, e_freeze;
        int          e_addr;
        int          mode;

        rst = 1'b1; inst_d = 32'd0; dump_ready = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = $urandom;
        model_reset();
        @(posedge clk);
        @(posedge clk);

        for (int r = 0; r < 24; r++) begin
            mode = r % 3;
            for (int i = 0; i < 16; i++) mem[i] = $urandom;
            for (int cyc = 0; cyc < 140; cyc++) begin
                @(negedge clk);
                rst = (cyc < 2) || (r != 0 && $urandom_range(0, 399) == 0);
                v = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
                if (v == HALT) v = 32'd0;
                if (r == 0) begin
                    if (!rst && !m_halted && m_run == 10) v = HALT;
                end else if ($urandom_range(0, 24) == 0) begin
                    v = HALT;
                end
                inst_d = v;
                case (mode)
                    0:       dump_ready = 1'b1;
                    1:       dump_ready = cyc[0];
                    default: dump_ready = ($urandom_range(0, 2) != 0);
                endcase
                #1;
                e_dump   = m_halted && (m_since >= DRAIN) && (m_beats < DUMP_WORDS);
                e_done   = m_halted && (m_beats == DUMP_WORDS);
                e_last   = e_dump && (m_beats == DUMP_WORDS - 1);
                e_addr   = m_beats % (1 << ADDR_W);
                e_freeze = m_halted || (inst_d == HALT);

                check_eq("freeze",  32'(freeze_f),   32'(e_freeze));
                check_eq("bubble",  32'(bubble_d),   32'(e_freeze));
                check_eq("halted",  32'(halted),     32'(m_halted));
                check_eq("valid",   32'(dump_valid), 32'(e_dump));
                check_eq("dump_en", 32'(dump_en),    32'(e_dump));
                check_eq("last",    32'(dump_last),  32'(e_last));
                check_eq("done",    32'(done),       32'(e_done));
                check_eq("cycles",  cycle_count,     m_run);
                check_eq("addr",    32'(dump_addr),  32'(e_addr));
                if (e_dump) check_eq("data", dump_data, mem[e_addr]);

                if (rst) begin
                    model_reset();
                end else if (!m_halted) begin
                    m_run++;
                    if (inst_d == HALT) begin
                        m_halted = 1;
                        m_since  = 0;
                    end
                end else begin
                    if (e_dump && dump_ready) m_beats++;
                    if (m_since < 1000) m_since++;
                end
                @(posedge clk);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
